// File: rtl/tl_grant_finisher.sv
// Client-side TileLink Grant sink: registers Grant beats toward the client and
// queues a Finish (endpoints swapped) on the last beat of every acked grant.
module tl_grant_finisher #(
   parameter int          LN_ENDPOINTS        = 2,
   parameter int          CLIENT_XACT_ID_BITS = 5,
   parameter int          MASTER_XACT_ID_BITS = 6,
   parameter int          DATA_BITS           = 128,
   parameter int          GRANT_TYPE_WIDTH    = 4,
   parameter int          DATA_BEATS          = 4,
   parameter logic [15:0] DATA_GTYPE_MASK     = 16'h0007,
   parameter logic [15:0] ACK_GTYPE_MASK      = 16'h00FF,
   parameter int          FINISH_DEPTH        = 4
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           gin_valid,
   output logic                           gin_ready,
   input  logic [LN_ENDPOINTS-1:0]        gin_src,
   input  logic [LN_ENDPOINTS-1:0]        gin_dst,
   input  logic [CLIENT_XACT_ID_BITS-1:0] gin_client_xact_id,
   input  logic [MASTER_XACT_ID_BITS-1:0] gin_master_xact_id,
   input  logic [DATA_BITS-1:0]           gin_data,
   input  logic [GRANT_TYPE_WIDTH-1:0]    gin_g_type,
   output logic                           gout_valid,
   input  logic                           gout_ready,
   output logic [CLIENT_XACT_ID_BITS-1:0] gout_client_xact_id,
   output logic [MASTER_XACT_ID_BITS-1:0] gout_master_xact_id,
   output logic [DATA_BITS-1:0]           gout_data,
   output logic [GRANT_TYPE_WIDTH-1:0]    gout_g_type,
   output logic                           gout_last,
   output logic                           fin_valid,
   input  logic                           fin_ready,
   output logic [LN_ENDPOINTS-1:0]        fin_src,
   output logic [LN_ENDPOINTS-1:0]        fin_dst,
   output logic [MASTER_XACT_ID_BITS-1:0] fin_master_xact_id
);

   localparam int BEAT_W = $clog2(DATA_BEATS);
   localparam int PTR_W  = $clog2(FINISH_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int FIN_W  = 2*LN_ENDPOINTS + MASTER_XACT_ID_BITS;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BEATS - 1);
   localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FINISH_DEPTH);

   logic                           full_q, full_d;
   logic [BEAT_W-1:0]              beat_cnt_q, beat_cnt_d;
   logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]               count_q, count_d;
   logic [FIN_W-1:0]               fin_mem_q [FINISH_DEPTH];
   logic [CLIENT_XACT_ID_BITS-1:0] cxid_q;
   logic [MASTER_XACT_ID_BITS-1:0] mxid_q;
   logic [DATA_BITS-1:0]           data_q;
   logic [GRANT_TYPE_WIDTH-1:0]    gtype_q;
   logic                           last_q;

   logic data_grant, beat_last, needs_fin;
   logic accept, out_pop, fin_push, fin_pop;

   assign data_grant = DATA_GTYPE_MASK[gin_g_type];
   assign beat_last  = !data_grant || (beat_cnt_q == LAST_BEAT);
   assign needs_fin  = beat_last && ACK_GTYPE_MASK[gin_g_type];

   // A full Finish FIFO blocks the push even if it pops this cycle, keeping
   // gin_ready independent of fin_ready.
   assign gin_ready = rstn && (!full_q || gout_ready) &&
                      (!needs_fin || (count_q < FIFO_FULL));
   assign accept    = gin_valid && gin_ready;
   assign out_pop   = full_q && gout_ready;
   assign fin_push  = accept && needs_fin;
   assign fin_pop   = fin_valid && fin_ready;

   always_comb begin
      full_d     = full_q;
      beat_cnt_d = beat_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (accept)
         full_d = 1'b1;
      else if (out_pop)
         full_d = 1'b0;
      if (accept && data_grant)
         beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      if (fin_push)
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fin_pop)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({fin_push, fin_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         full_q     <= 1'b0;
         beat_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         cxid_q     <= '0;
         mxid_q     <= '0;
         data_q     <= '0;
         gtype_q    <= '0;
         last_q     <= 1'b0;
         for (int i = 0; i < FINISH_DEPTH; i++)
            fin_mem_q[i] <= '0;
      end else begin
         full_q     <= full_d;
         beat_cnt_q <= beat_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         if (accept) begin
            cxid_q  <= gin_client_xact_id;
            mxid_q  <= gin_master_xact_id;
            data_q  <= gin_data;
            gtype_q <= gin_g_type;
            last_q  <= beat_last;
         end
         // Finish goes back to the issuing manager: endpoints swapped.
         if (fin_push)
            fin_mem_q[wr_ptr_q] <= {gin_dst, gin_src, gin_master_xact_id};
      end
   end

   assign gout_valid          = full_q;
   assign gout_client_xact_id = cxid_q;
   assign gout_master_xact_id = mxid_q;
   assign gout_data           = data_q;
   assign gout_g_type         = gtype_q;
   assign gout_last           = last_q;

   assign fin_valid = (count_q != '0);
   assign {fin_src, fin_dst, fin_master_xact_id} = fin_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_tl_grant_finisher.sv
// Bench for tl_grant_finisher: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the Grant/Finish flow.
module tb_tl_grant_finisher;

   localparam int DB = 4;
   localparam int FD = 4;

   logic [15:0] dmask = 16'h0007;
   logic [15:0] amask = 16'h00FF;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         gin_valid = 1'b0;
   logic         gin_ready;
   logic [1:0]   gin_src = '0, gin_dst = '0;
   logic [4:0]   gin_client_xact_id = '0;
   logic [5:0]   gin_master_xact_id = '0;
   logic [127:0] gin_data = '0;
   logic [3:0]   gin_g_type = '0;
   logic         gout_valid;
   logic         gout_ready = 1'b0;
   logic [4:0]   gout_client_xact_id;
   logic [5:0]   gout_master_xact_id;
   logic [127:0] gout_data;
   logic [3:0]   gout_g_type;
   logic         gout_last;
   logic         fin_valid;
   logic         fin_ready = 1'b0;
   logic [1:0]   fin_src, fin_dst;
   logic [5:0]   fin_master_xact_id;

   tl_grant_finisher dut (
      .clk(clk), .rstn(rstn),
      .gin_valid(gin_valid), .gin_ready(gin_ready),
      .gin_src(gin_src), .gin_dst(gin_dst),
      .gin_client_xact_id(gin_client_xact_id),
      .gin_master_xact_id(gin_master_xact_id),
      .gin_data(gin_data), .gin_g_type(gin_g_type),
      .gout_valid(gout_valid), .gout_ready(gout_ready),
      .gout_client_xact_id(gout_client_xact_id),
      .gout_master_xact_id(gout_master_xact_id),
      .gout_data(gout_data), .gout_g_type(gout_g_type),
      .gout_last(gout_last),
      .fin_valid(fin_valid), .fin_ready(fin_ready),
      .fin_src(fin_src), .fin_dst(fin_dst),
      .fin_master_xact_id(fin_master_xact_id)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]   cx;
      logic [5:0]   mx;
      logic [127:0] dat;
      logic [3:0]   gt;
      logic         last;
   } beat_t;

   typedef struct packed {
      logic [1:0] src;
      logic [1:0] dst;
      logic [5:0] mx;
   } fin_t;

   beat_t out_q[$];
   fin_t  fin_q[$];
   int    gpos = 0;
   int    n_chk = 0;
   int    n_pass = 0;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // One clock: drive at negedge, compare against the model, then advance it.
   task automatic cycle(input logic v, input logic [3:0] gt, input logic [1:0] s,
                        input logic [1:0] d, input logic [4:0] cx, input logic [5:0] mx,
                        input logic [127:0] dat, input logic gr, input logic fr,
                        output logic acc);
      logic is_data, last, nf, exp_rdy;
      beat_t b;
      fin_t  f;
      gin_valid = v; gin_g_type = gt; gin_src = s; gin_dst = d;
      gin_client_xact_id = cx; gin_master_xact_id = mx; gin_data = dat;
      gout_ready = gr; fin_ready = fr;
      #1;
      is_data = dmask[gt];
      last    = !is_data || (gpos == DB - 1);
      nf      = last && amask[gt];
      exp_rdy = rstn && (out_q.size() == 0 || gr) && (!nf || fin_q.size() < FD);
      check_eq("gin_ready", 128'(gin_ready), 128'(exp_rdy));
      check_eq("gout_valid", 128'(gout_valid), 128'(out_q.size() != 0));
      if (out_q.size() != 0) begin
         check_eq("gout_cxid", 128'(gout_client_xact_id), 128'(out_q[0].cx));
         check_eq("gout_mxid", 128'(gout_master_xact_id), 128'(out_q[0].mx));
         check_eq("gout_data", gout_data, out_q[0].dat);
         check_eq("gout_g_type", 128'(gout_g_type), 128'(out_q[0].gt));
         check_eq("gout_last", 128'(gout_last), 128'(out_q[0].last));
      end
      check_eq("fin_valid", 128'(fin_valid), 128'(fin_q.size() != 0));
      if (fin_q.size() != 0) begin
         check_eq("fin_src", 128'(fin_src), 128'(fin_q[0].src));
         check_eq("fin_dst", 128'(fin_dst), 128'(fin_q[0].dst));
         check_eq("fin_mxid", 128'(fin_master_xact_id), 128'(fin_q[0].mx));
      end
      acc = v && exp_rdy;
      if (!rstn) begin
         out_q.delete();
         fin_q.delete();
         gpos = 0;
      end else begin
         if (out_q.size() != 0 && gr) void'(out_q.pop_front());
         if (fin_q.size() != 0 && fr) void'(fin_q.pop_front());
         if (acc) begin
            b.cx = cx; b.mx = mx; b.dat = dat; b.gt = gt; b.last = last;
            out_q.push_back(b);
            if (is_data) gpos = (gpos + 1) % DB;
            if (nf) begin
               f.src = d; f.dst = s; f.mx = mx;
               fin_q.push_back(f);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic gr, input logic fr);
      logic acc;
      cycle(1'b0, 4'd0, 2'd0, 2'd0, 5'd0, 6'd0, 128'd0, gr, fr, acc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic acc;
      int   left;
      logic [3:0] rgt;
      logic [1:0] rs, rd;
      logic [4:0] rcx;
      logic [5:0] rmx;
      logic [127:0] rdat;
      logic rv, rgr, rfr;

      @(negedge clk);
      idle(1'b1, 1'b1);
      check_eq("rst_gout_valid", 128'(gout_valid), 128'd0);
      check_eq("rst_gout_last", 128'(gout_last), 128'd0);
      check_eq("rst_fin_valid", 128'(fin_valid), 128'd0);
      check_eq("rst_gin_ready", 128'(gin_ready), 128'd0);
      rstn = 1'b1;
      idle(1'b1, 1'b1);

      // Single non-data ack grant
      cycle(1'b1, 4'd4, 2'd1, 2'd0, 5'd3, 6'h12, 128'h55, 1'b1, 1'b1, acc);
      check_eq("t1_acc", 128'(acc), 128'd1);
      check_eq("t1_gout_valid", 128'(gout_valid), 128'd1);
      check_eq("t1_gout_last", 128'(gout_last), 128'd1);
      check_eq("t1_fin_valid", 128'(fin_valid), 128'd1);
      check_eq("t1_fin_src", 128'(fin_src), 128'd0);
      check_eq("t1_fin_dst", 128'(fin_dst), 128'd1);
      check_eq("t1_fin_mxid", 128'(fin_master_xact_id), 128'h12);
      idle(1'b1, 1'b1);
      check_eq("t1_one_fin", 128'(fin_valid), 128'd0);

      // Four-beat data grant, back-to-back
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 4'd0, 2'd2, 2'd1, 5'd7, 6'h21, 128'(10 + i), 1'b1, 1'b1, acc);
         check_eq("t2_acc", 128'(acc), 128'd1);
         check_eq("t2_data", gout_data, 128'(10 + i));
         check_eq("t2_last", 128'(gout_last), 128'(i == 3));
         check_eq("t2_fin_valid", 128'(fin_valid), 128'(i == 3));
      end
      check_eq("t2_fin_src", 128'(fin_src), 128'd1);
      check_eq("t2_fin_dst", 128'(fin_dst), 128'd2);
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b1);

      // Finish FIFO fills with fin_ready low
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 4'd5, 2'(i), 2'(3 - i), 5'(i), 6'(8 + i), 128'(i), 1'b1, 1'b0, acc);
         check_eq("t3_acc", 128'(acc), 128'(i < 4));
      end
      cycle(1'b1, 4'd5, 2'd0, 2'd3, 5'd4, 6'd12, 128'd4, 1'b1, 1'b1, acc);
      check_eq("t3_full_pop_acc", 128'(acc), 128'd0);
      cycle(1'b1, 4'd5, 2'd0, 2'd3, 5'd4, 6'd12, 128'd4, 1'b1, 1'b0, acc);
      check_eq("t3_fifth_acc", 128'(acc), 128'd1);
      for (int i = 0; i < 6; i++) idle(1'b1, 1'b1);

      // Client backpressure with a beat pending
      cycle(1'b1, 4'd4, 2'd3, 2'd2, 5'd9, 6'h31, 128'hBEEF, 1'b0, 1'b1, acc);
      check_eq("t4_first_acc", 128'(acc), 128'd1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 4'd4, 2'd1, 2'd1, 5'd10, 6'h32, 128'hCAFE, 1'b0, 1'b1, acc);
         check_eq("t4_stall_acc", 128'(acc), 128'd0);
         check_eq("t4_stable_data", gout_data, 128'hBEEF);
      end
      cycle(1'b1, 4'd4, 2'd1, 2'd1, 5'd10, 6'h32, 128'hCAFE, 1'b1, 1'b1, acc);
      check_eq("t4_release_acc", 128'(acc), 128'd1);
      check_eq("t4_second_data", gout_data, 128'hCAFE);
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b1);

      // Non-ack grant type
      cycle(1'b1, 4'd8, 2'd2, 2'd3, 5'd1, 6'h3F, 128'h88, 1'b1, 1'b1, acc);
      check_eq("t5_gout_valid", 128'(gout_valid), 128'd1);
      check_eq("t5_fin_valid", 128'(fin_valid), 128'd0);
      idle(1'b1, 1'b1);
      check_eq("t5_fin_still0", 128'(fin_valid), 128'd0);

      // Randomized traffic, ending on a burst boundary
      left = 0;
      rgt = '0; rs = '0; rd = '0; rcx = '0; rmx = '0;
      for (int c = 0; c < 4000; c++) begin
         if (c >= 1500 && left == 0) break;
         if (left == 0) begin
            rgt  = 4'($urandom_range(0, 15));
            left = dmask[rgt] ? DB : 1;
            rs   = 2'($urandom);
            rd   = 2'($urandom);
            rcx  = 5'($urandom);
            rmx  = 6'($urandom);
         end
         rdat = {$urandom(), $urandom(), $urandom(), $urandom()};
         rv   = ($urandom_range(0, 3) != 0);
         rgr  = ($urandom_range(0, 3) != 0);
         rfr  = 1'($urandom_range(0, 1));
         cycle(rv, rgt, rs, rd, rcx, rmx, rdat, rgr, rfr, acc);
         if (acc) left--;
      end
      for (int i = 0; i < 8; i++) idle(1'b1, 1'b1);

      // Reset mid-burst with two Finishes queued
      cycle(1'b1, 4'd4, 2'd1, 2'd2, 5'd2, 6'h05, 128'h1, 1'b1, 1'b0, acc);
      cycle(1'b1, 4'd4, 2'd1, 2'd2, 5'd2, 6'h06, 128'h2, 1'b1, 1'b0, acc);
      cycle(1'b1, 4'd0, 2'd0, 2'd3, 5'd4, 6'h07, 128'h3, 1'b1, 1'b0, acc);
      cycle(1'b1, 4'd0, 2'd0, 2'd3, 5'd4, 6'h07, 128'h4, 1'b1, 1'b0, acc);
      check_eq("t6_pre_fin_valid", 128'(fin_valid), 128'd1);
      rstn = 1'b0;
      idle(1'b1, 1'b0);
      rstn = 1'b1;
      check_eq("t6_gout_valid", 128'(gout_valid), 128'd0);
      check_eq("t6_fin_valid", 128'(fin_valid), 128'd0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 4'd1, 2'd2, 2'd0, 5'd6, 6'h2A, 128'(100 + i), 1'b1, 1'b1, acc);
         check_eq("t6_acc", 128'(acc), 128'd1);
         check_eq("t6_last", 128'(gout_last), 128'(i == 3));
      end
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
